regfile_host_master: RTL and testbench

- Command-driven initiator that owns the register file's read-port-0 and write port on behalf of a host/debug link.
- Accepts READ, WRITE, COPY and DUMP commands over a valid/ready request channel.
- Issues the register-file accesses and returns results over a valid/ready response channel.
- Sits between the debug transport and the core/host port mux; `busy` steers that mux.

---
 rtl/regfile_host_master_pkg.sv | 24 ++
 rtl/regfile_host_master_if.sv | 34 +++
 rtl/regfile_host_master_rsp_slice.sv | 55 +++++
 rtl/regfile_host_master.sv | 171 +++++++++++++++++
 tb/tb_regfile_host_master.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_host_master_pkg.sv
// Shared constants and types for the register-file host master:
// command opcodes, FSM state encoding and default widths.
package kgp_rf_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;
    localparam int NUM_REGS   = 32;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_COPY  = 2'd2;
    localparam logic [1:0] OP_DUMP  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_CP_RD,
        S_CP_WR,
        S_DMP_RD,
        S_RSP
    } state_t;

endpackage

// File: rtl/regfile_host_master_if.sv
// Host-side command/response channels of the register-file host master.
// The master modport is the host link, the slave modport is the block itself.
interface regfile_host_master_if
    import kgp_rf_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_addr2;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_last;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_addr2, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_addr, rsp_last, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_addr2, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_addr, rsp_last, rsp_err
    );

endinterface

// File: rtl/regfile_host_master_rsp_slice.sv
// Response holding register: loads one beat and keeps it stable
// until the consumer takes it with a valid/ready handshake.
module rf_rsp_slice
    import kgp_rf_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_last,
    input  logic              i_err,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last,
    output logic              o_err
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] r_addr;
    logic              r_last;
    logic              r_err;

    // Payload only changes on a load, so it stays put while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_addr  <= '0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_addr  <= i_addr;
            r_last  <= i_last;
            r_err   <= i_err;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_addr  = r_addr;
    assign o_last  = r_last;
    assign o_err   = r_err;

endmodule

// File: rtl/regfile_host_master.sv
// Command-driven initiator owning the register file's read port 0 and write
// port on behalf of a host/debug link; busy steers the core/host port mux.
module regfile_host_master
    import kgp_rf_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter bit ZERO_PROTECT = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_host_master_if.slave  host,
    output logic                  busy,
    output logic [ADDR_W-1:0]     rf_raddr0,
    input  logic [DATA_W-1:0]     rf_rdata0,
    output logic [ADDR_W-1:0]     rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  rf_wren
);

    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_raddr;
    logic [ADDR_W-1:0] r_waddr;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_wdata;

    logic              w_accept;
    logic              w_rspValid;
    logic              w_rspFire;
    logic              w_lastBeat;
    logic              w_suppress;
    logic              w_load;
    logic [DATA_W-1:0] w_ldData;
    logic [ADDR_W-1:0] w_ldAddr;
    logic              w_ldLast;
    logic              w_ldErr;

    assign w_accept   = (r_state == S_IDLE) && host.cmd_valid;
    assign w_rspFire  = (r_state == S_RSP) && w_rspValid && host.rsp_ready;
    assign w_lastBeat = (r_cnt == LAST_REG);
    assign w_suppress = ZERO_PROTECT && (r_waddr == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Every access state loads the response slice on its way into RSP.
    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_ldData = r_wdata;
        w_ldAddr = r_addr;
        w_ldLast = 1'b1;
        w_ldErr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (host.cmd_valid) begin
                    case (host.cmd_op)
                        OP_READ:  w_next = S_RD;
                        OP_WRITE: w_next = S_WR;
                        OP_COPY:  w_next = S_CP_RD;
                        default:  w_next = S_DMP_RD;
                    endcase
                end
            end
            S_RD: begin
                w_load   = 1'b1;
                w_ldData = rf_rdata0;
                w_next   = S_RSP;
            end
            S_WR, S_CP_WR: begin
                w_load  = 1'b1;
                w_ldErr = w_suppress;
                w_next  = S_RSP;
            end
            S_CP_RD: begin
                w_next = S_CP_WR;
            end
            S_DMP_RD: begin
                w_load   = 1'b1;
                w_ldData = rf_rdata0;
                w_ldAddr = r_cnt;
                w_ldLast = w_lastBeat;
                w_next   = S_RSP;
            end
            S_RSP: begin
                if (w_rspValid && host.rsp_ready) begin
                    w_next = (r_op == OP_DUMP && !w_lastBeat) ? S_DMP_RD : S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Read/write addresses are registered so they hold between accesses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= OP_READ;
            r_addr  <= '0;
            r_raddr <= '0;
            r_waddr <= '0;
            r_cnt   <= '0;
            r_wdata <= '0;
        end else begin
            if (w_accept) begin
                r_op   <= host.cmd_op;
                r_addr <= host.cmd_addr;
                case (host.cmd_op)
                    OP_READ:  r_raddr <= host.cmd_addr;
                    OP_WRITE: begin
                        r_waddr <= host.cmd_addr;
                        r_wdata <= host.cmd_wdata;
                    end
                    OP_COPY: begin
                        r_raddr <= host.cmd_addr2;
                        r_waddr <= host.cmd_addr;
                    end
                    default:  r_raddr <= r_cnt;
                endcase
            end
            if (r_state == S_CP_RD) begin
                r_wdata <= rf_rdata0;
            end
            if (w_rspFire && r_op == OP_DUMP) begin
                if (w_lastBeat) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                    r_raddr <= r_cnt + 1'b1;
                end
            end
        end
    end

    rf_rsp_slice #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rspSlice (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_ready (host.rsp_ready),
        .i_data  (w_ldData),
        .i_addr  (w_ldAddr),
        .i_last  (w_ldLast),
        .i_err   (w_ldErr),
        .o_valid (w_rspValid),
        .o_data  (host.rsp_data),
        .o_addr  (host.rsp_addr),
        .o_last  (host.rsp_last),
        .o_err   (host.rsp_err)
    );

    assign host.rsp_valid = w_rspValid;
    assign host.cmd_ready = (r_state == S_IDLE);
    assign busy           = (r_state != S_IDLE);
    assign rf_raddr0      = r_raddr;
    assign rf_waddr       = r_waddr;
    assign rf_wdata       = r_wdata;
    assign rf_wren        = !rst && !w_suppress && (r_state == S_WR || r_state == S_CP_WR);

endmodule

// File: tb/tb_regfile_host_master.sv
// Scoreboard bench for regfile_host_master: a reference register array predicts
// responses and writes at issue time; a negedge monitor checks what the DUT presents.
module tb_regfile_host_master;
    import kgp_rf_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        last;
        logic        err;
        int          lat;
    } rsp_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    logic memClear;
    always #5 clk = ~clk;

    regfile_host_master_if #(.ADDR_W(5), .DATA_W(32)) if0 ();
    regfile_host_master_if #(.ADDR_W(5), .DATA_W(32)) if1 ();

    logic        busy0, busy1, wren0, wren1;
    logic [4:0]  raddr0, waddr0, raddr1, waddr1;
    logic [31:0] rdata0, wdata0, rdata1, wdata1;

    regfile_host_master #(.ADDR_W(5), .DATA_W(32), .ZERO_PROTECT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .host(if0), .busy(busy0),
        .rf_raddr0(raddr0), .rf_rdata0(rdata0),
        .rf_waddr(waddr0), .rf_wdata(wdata0), .rf_wren(wren0)
    );

    regfile_host_master #(.ADDR_W(5), .DATA_W(32), .ZERO_PROTECT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .host(if1), .busy(busy1),
        .rf_raddr0(raddr1), .rf_rdata0(rdata1),
        .rf_waddr(waddr1), .rf_wdata(wdata1), .rf_wren(wren1)
    );

    // Environment register files with asynchronous read.
    logic [31:0] mem0 [32];
    logic [31:0] mem1 [32];
    always @(posedge clk) begin
        if (memClear) begin
            for (int i = 0; i < 32; i++) begin
                mem0[i] <= '0;
                mem1[i] <= '0;
            end
        end else begin
            if (wren0) mem0[waddr0] <= wdata0;
            if (wren1) mem1[waddr1] <= wdata1;
        end
    end
    assign rdata0 = mem0[raddr0];
    assign rdata1 = mem1[raddr1];

    logic [31:0] refMem [32];
    rsp_t rspQ[$];
    wr_t  wrQ[$];
    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int readyMode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void pushRsp(input logic [31:0] d, input logic [4:0] a, input logic l, input logic e, input int lat);
        rsp_t r;
        r.data = d; r.addr = a; r.last = l; r.err = e; r.lat = lat;
        rspQ.push_back(r);
    endfunction

    function automatic void pushWr(input logic [4:0] a, input logic [31:0] d, input int c);
        wr_t w;
        w.addr = a; w.data = d; w.cyc = c;
        wrQ.push_back(w);
    endfunction

    // Response ready pattern: 0 always, 1 toggle, 2 random, 3 held low.
    always @(posedge clk) begin
        #2;
        case (readyMode)
            0:       if0.rsp_ready = 1'b1;
            1:       if0.rsp_ready = (if0.rsp_ready === 1'b1) ? 1'b0 : 1'b1;
            2:       if0.rsp_ready = 1'($urandom_range(0, 1));
            default: if0.rsp_ready = 1'b0;
        endcase
    end

    // Monitor: every presented beat must match the head of the expected queue.
    logic prevValid = 1'b0;
    rsp_t monR;
    wr_t  monW;
    always @(negedge clk) begin
        if (!rst && !memClear) begin
            checkOutput("cmdRspOverlap", 64'(if0.rsp_valid & if0.cmd_ready), 64'd0);
            if (wren0) begin
                checkOutput("writeExpected", 64'(wrQ.size() != 0), 64'd1);
                if (wrQ.size() != 0) begin
                    monW = wrQ.pop_front();
                    checkOutput("wrAddr", 64'(waddr0), 64'(monW.addr));
                    checkOutput("wrData", 64'(wdata0), 64'(monW.data));
                    checkOutput("wrCycle", 64'(cyc), 64'(monW.cyc));
                end
            end
            if (if0.rsp_valid) begin
                checkOutput("rspExpected", 64'(rspQ.size() != 0), 64'd1);
                if (rspQ.size() != 0) begin
                    monR = rspQ[0];
                    if (!prevValid && monR.lat >= 0) checkOutput("rspLatency", 64'(cyc), 64'(monR.lat));
                    checkOutput("rspData", 64'(if0.rsp_data), 64'(monR.data));
                    checkOutput("rspAddr", 64'(if0.rsp_addr), 64'(monR.addr));
                    checkOutput("rspLast", 64'(if0.rsp_last), 64'(monR.last));
                    checkOutput("rspErr", 64'(if0.rsp_err), 64'(monR.err));
                    if (if0.rsp_ready) void'(rspQ.pop_front());
                end
            end
        end
        prevValid = if0.rsp_valid;
    end

    // Issue one command to dut0; when modelled, predict its writes and responses.
    task automatic applyStimulus(input logic [1:0] op, input logic [4:0] a, input logic [4:0] a2,
                                 input logic [31:0] wd, input bit useModel, output int acceptCyc);
        int waited = 0;
        logic [31:0] v;
        @(negedge clk);
        if0.cmd_valid = 1'b1;
        if0.cmd_op    = op;
        if0.cmd_addr  = a;
        if0.cmd_addr2 = a2;
        if0.cmd_wdata = wd;
        while (!if0.cmd_ready && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        acceptCyc = cyc;
        if (!if0.cmd_ready) begin
            checkOutput("cmdAcceptTimeout", 64'(if0.cmd_ready), 64'd1);
            if0.cmd_valid = 1'b0;
            return;
        end
        if (useModel) begin
            case (op)
                OP_READ: pushRsp(refMem[a], a, 1'b1, 1'b0, acceptCyc + 2);
                OP_WRITE: begin
                    refMem[a] = wd;
                    pushWr(a, wd, acceptCyc + 1);
                    pushRsp(wd, a, 1'b1, 1'b0, acceptCyc + 2);
                end
                OP_COPY: begin
                    v = refMem[a2];
                    refMem[a] = v;
                    pushWr(a, v, acceptCyc + 2);
                    pushRsp(v, a, 1'b1, 1'b0, acceptCyc + 3);
                end
                default: begin
                    for (int i = 0; i < 32; i++)
                        pushRsp(refMem[i], 5'(i), (i == 31), 1'b0, (i == 0) ? acceptCyc + 2 : -1);
                end
            endcase
        end
        @(posedge clk);
        #1 if0.cmd_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int waited = 0;
        while ((rspQ.size() != 0 || wrQ.size() != 0) && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("drainRemaining", 64'(rspQ.size() + wrQ.size()), 64'd0);
    endtask

    // Single command on the zero-protected instance, checked directly.
    task automatic runZp(input logic [1:0] op, input logic [4:0] a, input logic [4:0] a2, input logic [31:0] wd,
                         input logic [31:0] expData, input logic [4:0] expAddr, input logic expErr, input int expWrens);
        int waited = 0;
        int wrens = 0;
        bit got = 0;
        @(negedge clk);
        if1.cmd_valid = 1'b1;
        if1.cmd_op    = op;
        if1.cmd_addr  = a;
        if1.cmd_addr2 = a2;
        if1.cmd_wdata = wd;
        while (!if1.cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("zpAccept", 64'(if1.cmd_ready), 64'd1);
        @(posedge clk);
        #1 if1.cmd_valid = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (wren1) wrens++;
            if (if1.rsp_valid) begin
                got = 1;
                checkOutput("zpRspData", 64'(if1.rsp_data), 64'(expData));
                checkOutput("zpRspAddr", 64'(if1.rsp_addr), 64'(expAddr));
                checkOutput("zpRspErr", 64'(if1.rsp_err), 64'(expErr));
                checkOutput("zpRspLast", 64'(if1.rsp_last), 64'd1);
            end
        end
        checkOutput("zpRspSeen", 64'(got), 64'd1);
        checkOutput("zpWrenCount", 64'(wrens), 64'(expWrens));
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        int r;
        int waited;
        logic [1:0] op;
        rst = 1'b1;
        memClear = 1'b1;
        if0.cmd_valid = 1'b0; if0.cmd_op = '0; if0.cmd_addr = '0; if0.cmd_addr2 = '0; if0.cmd_wdata = '0;
        if1.cmd_valid = 1'b0; if1.cmd_op = '0; if1.cmd_addr = '0; if1.cmd_addr2 = '0; if1.cmd_wdata = '0;
        if1.rsp_ready = 1'b1;
        for (int i = 0; i < 32; i++) refMem[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        memClear = 1'b0;

        @(negedge clk);
        checkOutput("rstRspValid", 64'(if0.rsp_valid), 64'd0);
        checkOutput("rstRspLast", 64'(if0.rsp_last), 64'd0);
        checkOutput("rstRspErr", 64'(if0.rsp_err), 64'd0);
        checkOutput("rstRspData", 64'(if0.rsp_data), 64'd0);
        checkOutput("rstRspAddr", 64'(if0.rsp_addr), 64'd0);
        checkOutput("rstBusy", 64'(busy0), 64'd0);
        checkOutput("rstWren", 64'(wren0), 64'd0);
        checkOutput("rstRaddr", 64'(raddr0), 64'd0);
        checkOutput("rstWaddr", 64'(waddr0), 64'd0);
        checkOutput("rstWdata", 64'(wdata0), 64'd0);
        checkOutput("rstCmdReady", 64'(if0.cmd_ready), 64'd1);

        $display("[TB] directed write/read/copy");
        readyMode = 0;
        applyStimulus(OP_WRITE, 5'd5, 5'd0, 32'hDEADBEEF, 1'b1, acc);
        applyStimulus(OP_READ, 5'd5, 5'd0, 32'h0, 1'b1, acc);
        applyStimulus(OP_COPY, 5'd9, 5'd5, 32'h0, 1'b1, acc);
        applyStimulus(OP_READ, 5'd9, 5'd0, 32'h0, 1'b1, acc);
        applyStimulus(OP_COPY, 5'd9, 5'd9, 32'h0, 1'b1, acc);
        waitDrain();

        $display("[TB] preload and dump with toggling ready");
        for (int i = 0; i < 32; i++)
            applyStimulus(OP_WRITE, 5'(i), 5'd0, 32'h100 + 32'(i), 1'b1, acc);
        waitDrain();
        readyMode = 1;
        applyStimulus(OP_DUMP, 5'd0, 5'd0, 32'h0, 1'b1, acc);
        waitDrain();

        $display("[TB] long response stall");
        readyMode = 3;
        applyStimulus(OP_READ, 5'd7, 5'd0, 32'h0, 1'b1, acc);
        waited = 0;
        while (!if0.rsp_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        for (int k = 0; k < 10; k++) begin
            checkOutput("stallValid", 64'(if0.rsp_valid), 64'd1);
            checkOutput("stallCmdReady", 64'(if0.cmd_ready), 64'd0);
            checkOutput("stallBusy", 64'(busy0), 64'd1);
            @(negedge clk);
        end
        readyMode = 0;
        @(negedge clk);
        checkOutput("handshakeCmdReady", 64'(if0.cmd_ready), 64'd0);
        @(negedge clk);
        checkOutput("postHandshakeCmdReady", 64'(if0.cmd_ready), 64'd1);
        waitDrain();

        $display("[TB] reset during copy write");
        applyStimulus(OP_COPY, 5'd12, 5'd5, 32'h0, 1'b0, acc);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("wrenDuringReset", 64'(wren0), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("abortRspValid", 64'(if0.rsp_valid), 64'd0);
        checkOutput("abortRspLast", 64'(if0.rsp_last), 64'd0);
        checkOutput("abortRspData", 64'(if0.rsp_data), 64'd0);
        checkOutput("abortRspAddr", 64'(if0.rsp_addr), 64'd0);
        checkOutput("abortBusy", 64'(busy0), 64'd0);
        checkOutput("abortWren", 64'(wren0), 64'd0);
        checkOutput("abortRaddr", 64'(raddr0), 64'd0);
        checkOutput("abortWaddr", 64'(waddr0), 64'd0);
        checkOutput("abortWdata", 64'(wdata0), 64'd0);
        @(negedge clk);
        checkOutput("abortCmdReady", 64'(if0.cmd_ready), 64'd1);
        applyStimulus(OP_READ, 5'd12, 5'd0, 32'h0, 1'b1, acc);
        waitDrain();

        $display("[TB] randomized commands");
        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 9);
            readyMode = $urandom_range(0, 2);
            op = (r < 4) ? OP_READ : (r < 7) ? OP_WRITE : (r < 9) ? OP_COPY : OP_DUMP;
            applyStimulus(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), $urandom, 1'b1, acc);
        end
        waitDrain();
        readyMode = 0;

        $display("[TB] zero-protected instance");
        runZp(OP_WRITE, 5'd0, 5'd0, 32'h1234, 32'h1234, 5'd0, 1'b1, 0);
        runZp(OP_WRITE, 5'd3, 5'd0, 32'h55, 32'h55, 5'd3, 1'b0, 1);
        runZp(OP_COPY, 5'd0, 5'd3, 32'h0, 32'h55, 5'd0, 1'b1, 0);
        runZp(OP_COPY, 5'd7, 5'd3, 32'h0, 32'h55, 5'd7, 1'b0, 1);
        runZp(OP_READ, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b0, 0);
        runZp(OP_READ, 5'd7, 5'd0, 32'h0, 32'h55, 5'd7, 1'b0, 0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
